traffic_light_fsm: RTL and testbench

Single-intersection traffic-light controller. A Moore state machine cycles RED → GREEN → YELLOW → RED, holding each phase for a parameterised number of clock cycles. It drives a 3-bit one-hot lamp vector. It is a free-running leaf block with no inputs other than clock and reset.

---
 rtl/traffic_light_pkg.sv | 21 ++
 rtl/traffic_light_fsm_phase_timer.sv | 33 +++
 rtl/traffic_light_fsm.sv | 89 ++++++++
 tb/tb_traffic_light_fsm.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/traffic_light_pkg.sv
// Shared types and lamp constants for the single-intersection traffic-light controller.
package traffic_light_pkg;

    // 2'b11 is deliberately left unused; the FSM treats it as a fail-safe red.
    typedef enum logic [1:0] {
        ST_RED    = 2'b00,
        ST_GREEN  = 2'b01,
        ST_YELLOW = 2'b10
    } state_t;

    localparam logic [2:0] LIGHT_RED    = 3'b100;
    localparam logic [2:0] LIGHT_YELLOW = 3'b010;
    localparam logic [2:0] LIGHT_GREEN  = 3'b001;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/traffic_light_fsm_phase_timer.sv
// Phase timer: counts up from 0 after restart and flags when the terminal value is reached.
module phase_timer #(
    parameter int unsigned CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] load_i,
    input  logic             restart_i,
    output logic             done_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // >= rather than == so a corrupted count still terminates the phase.
    assign done_o = (cnt_q >= load_i);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (restart_i) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/traffic_light_fsm.sv
// Moore traffic-light controller cycling RED -> GREEN -> YELLOW with per-phase durations.
module traffic_light_fsm
    import traffic_light_pkg::*;
#(
    parameter int RED_CYCLES    = 5,
    parameter int GREEN_CYCLES  = 5,
    parameter int YELLOW_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    output logic [2:0] light
);

    localparam int MAX_DUR   = max3(RED_CYCLES, GREEN_CYCLES, YELLOW_CYCLES);
    localparam int CNT_W_RAW = $clog2(MAX_DUR + 1);
    localparam int CNT_W     = (CNT_W_RAW < 1) ? 1 : CNT_W_RAW;

    localparam logic [CNT_W-1:0] RED_TERM    = CNT_W'(RED_CYCLES - 1);
    localparam logic [CNT_W-1:0] GREEN_TERM  = CNT_W'(GREEN_CYCLES - 1);
    localparam logic [CNT_W-1:0] YELLOW_TERM = CNT_W'(YELLOW_CYCLES - 1);

    if (RED_CYCLES < 1 || GREEN_CYCLES < 1 || YELLOW_CYCLES < 1) begin : g_bad_duration
        $fatal(1, "traffic_light_fsm: every phase duration must be at least 1 cycle");
    end

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] term;
    logic             done;
    logic             restart;

    phase_timer #(
        .CNT_W(CNT_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load_i   (term),
        .restart_i(restart),
        .done_o   (done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RED;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        restart = 1'b0;
        term    = RED_TERM;
        light   = LIGHT_RED;
        unique case (state_q)
            ST_RED: begin
                term  = RED_TERM;
                light = LIGHT_RED;
                if (done) begin
                    state_d = ST_GREEN;
                    restart = 1'b1;
                end
            end
            ST_GREEN: begin
                term  = GREEN_TERM;
                light = LIGHT_GREEN;
                if (done) begin
                    state_d = ST_YELLOW;
                    restart = 1'b1;
                end
            end
            ST_YELLOW: begin
                term  = YELLOW_TERM;
                light = LIGHT_YELLOW;
                if (done) begin
                    state_d = ST_RED;
                    restart = 1'b1;
                end
            end
            default: begin
                // Unreachable encoding: show red and restart the cycle from a clean RED.
                state_d = ST_RED;
                restart = 1'b1;
                light   = LIGHT_RED;
            end
        endcase
    end

endmodule

// File: tb/tb_traffic_light_fsm.sv
// Self-checking bench for traffic_light_fsm against a time-since-reset phase model.
module tb_traffic_light_fsm;
    import traffic_light_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rst2 = 1'b1;
    logic [2:0] light;
    logic [2:0] light2;

    int unsigned vectors = 0;
    int unsigned errors  = 0;
    int unsigned t1 = 0;
    int unsigned t2 = 0;
    bit          inject = 1'b0;

    always #5 clk = ~clk;

    traffic_light_fsm dut (
        .clk  (clk),
        .rst  (rst),
        .light(light)
    );

    traffic_light_fsm #(
        .RED_CYCLES   (1),
        .GREEN_CYCLES (3),
        .YELLOW_CYCLES(1)
    ) dut2 (
        .clk  (clk),
        .rst  (rst2),
        .light(light2)
    );

    // Lamp expected t edges after the most recent reset edge (t = 0 is that edge).
    function automatic logic [2:0] model(input int unsigned t, input int unsigned r,
                                         input int unsigned g, input int unsigned y);
        int unsigned p;
        p = t % (r + g + y);
        if (p < r)          return 3'b100;
        else if (p < r + g) return 3'b001;
        else                return 3'b010;
    endfunction

    task automatic tick();
        @(posedge clk);
        if (rst || inject) t1 = 0; else t1++;
        if (rst2) t2 = 0; else t2++;
        #1;
    endtask

    task automatic test_reset();
        rst  = 1'b1;
        rst2 = 1'b1;
        tick();
        vectors++;
        if (light !== 3'b100) begin
            errors++;
            $display("FAIL reset_light: got %b expected %b", light, 3'b100);
        end
        vectors++;
        if (light2 !== 3'b100) begin
            errors++;
            $display("FAIL reset_light2: got %b expected %b", light2, 3'b100);
        end
        rst  = 1'b0;
        rst2 = 1'b0;
    endtask

    task automatic test_free_run();
        for (int i = 0; i < 30; i++) begin
            tick();
            vectors++;
            if (light !== model(t1, 5, 5, 2)) begin
                errors++;
                $display("FAIL free_run t=%0d: got %b expected %b", t1, light, model(t1, 5, 5, 2));
            end
        end
    endtask

    task automatic test_reset_mid_green();
        int unsigned guard;
        guard = 0;
        while ((t1 % 12) != 7 && guard < 24) begin
            tick();
            guard++;
        end
        vectors++;
        if (light !== 3'b001) begin
            errors++;
            $display("FAIL mid_green_setup: got %b expected %b", light, 3'b001);
        end
        rst = 1'b1;
        tick();
        vectors++;
        if (light !== 3'b100) begin
            errors++;
            $display("FAIL mid_green_reset: got %b expected %b", light, 3'b100);
        end
        rst = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            vectors++;
            if (light !== model(t1, 5, 5, 2)) begin
                errors++;
                $display("FAIL mid_green_after t=%0d: got %b expected %b", t1, light, model(t1, 5, 5, 2));
            end
        end
    endtask

    task automatic test_reset_hold();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            vectors++;
            if (light !== 3'b100) begin
                errors++;
                $display("FAIL reset_hold edge %0d: got %b expected %b", i, light, 3'b100);
            end
        end
        rst = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            tick();
            vectors++;
            if (light !== ((i == 5) ? 3'b001 : 3'b100)) begin
                errors++;
                $display("FAIL reset_release edge %0d: got %b expected %b", i, light,
                         (i == 5) ? 3'b001 : 3'b100);
            end
        end
    endtask

    task automatic test_override();
        for (int i = 0; i < 15; i++) begin
            tick();
            vectors++;
            if (light2 !== model(t2, 1, 3, 1)) begin
                errors++;
                $display("FAIL override t=%0d: got %b expected %b", t2, light2, model(t2, 1, 3, 1));
            end
        end
    endtask

    task automatic test_illegal_state();
        tick();
        tick();
        force dut.state_q = state_t'(2'b11);
        #1;
        vectors++;
        if (light !== 3'b100) begin
            errors++;
            $display("FAIL illegal_decode: got %b expected %b", light, 3'b100);
        end
        release dut.state_q;
        inject = 1'b1;
        tick();
        inject = 1'b0;
        for (int i = 0; i < 13; i++) begin
            vectors++;
            if (light !== model(t1, 5, 5, 2)) begin
                errors++;
                $display("FAIL illegal_recover t=%0d: got %b expected %b", t1, light, model(t1, 5, 5, 2));
            end
            tick();
        end
    endtask

    task automatic test_invariant();
        logic [2:0] prev;
        bit         was_rst;
        prev = light;
        for (int i = 0; i < 1000; i++) begin
            rst = ($urandom_range(0, 63) == 0);
            was_rst = rst;
            tick();
            vectors++;
            if (light !== model(t1, 5, 5, 2) || !$onehot(light)) begin
                errors++;
                $display("FAIL invariant_seq t=%0d: got %b expected %b", t1, light, model(t1, 5, 5, 2));
            end
            if (!was_rst) begin
                vectors++;
                if ((prev == 3'b001 && light == 3'b100) || (prev == 3'b100 && light == 3'b010)) begin
                    errors++;
                    $display("FAIL invariant_transition: got %b->%b expected no skip", prev, light);
                end
            end
            prev = light;
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_reset_mid_green();
        test_reset_hold();
        test_override();
        test_illegal_state();
        test_invariant();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
